compare_stream_unit: RTL and testbench
======================================

// Module: compare_stream_unit
// PURPOSE
//   Parametrised, pipelined successor to the 4-bit combinational comparison block.
//   Takes WIDTH-bit operand pairs over a valid/ready stream and produces a registered result.
//   Modes: EQ, GT, LT, MAX and MIN, plus running MAX/MIN accumulation across samples.
//   Supports signed or unsigned compare and a sticky overflow flag.
//   Sits between the ALU operand mux and the display/result register stage.
// PARAMETERS
//   WIDTH    4  operand width in bits (>=2)
//   COUNT_W  8  width of accumulated-sample counter
// PORTS
//   clk        in   1          system clock, all state on rising edge
//   reset      in   1          synchronous, active-high reset
//   in_valid   in   1          operand pair valid
//   in_ready   out  1          unit can accept operands this cycle
//   x          in   WIDTH      operand A
//   y          in   WIDTH      operand B (ignored in modes 5-7)
//   mode       in   3          operation select, sampled with operands
//   is_signed  in   1          1 = two's-complement compare, 0 = unsigned
//   of_in      in   1          upstream overflow flag
//   out_valid  out  1          result valid
//   out_ready  in   1          downstream accepts result
//   out_data   out  WIDTH+1    {of, result[WIDTH-1:0]}
//   acc_count  out  COUNT_W    samples folded into accumulator since clear
//   acc_empty  out  1          accumulator holds no sample
// BEHAVIOUR
//   Handshake
//   - Accept happens when in_valid && in_ready.
//   - in_ready = !out_valid || out_ready. Accept and drain in the same cycle is legal.
//   - Latency is 1 cycle: out_valid rises on the edge after an accept.
//   - Drain happens when out_valid && out_ready. If there is no new accept that cycle, out_valid falls.
//   - While out_valid && !out_ready, out_data, acc and acc_count hold stable.
//   - Operands presented without acceptance have no effect.
//   Modes (flag results are zero-extended to WIDTH)
//   - 0 EQ:   x==y
//   - 1 GT:   x>y
//   - 2 LT:   x<y
//   - 3 MAX:  x>y ? x : y  (ties give y)
//   - 4 MIN:  x<y ? x : y  (ties give y)
//   - 5 RMAX: acc <= acc_empty ? x : max(acc,x); result = new acc
//   - 6 RMIN: acc <= acc_empty ? x : min(acc,x); result = new acc
//   - 7 CLR:  acc<=0, acc_empty<=1, acc_count<=0, sticky_of<=0; result=0, of bit=0
//   Compare semantics
//   - is_signed applies to every compare, including the running modes.
//   - Signed compare uses full-width two's complement. No width extension of the result.
//   Overflow bit out_data[WIDTH]
//   - Modes 0-4: of_in of the accepted sample.
//   - Modes 5-6: sticky_of | of_in, and sticky_of is updated to that value.
//   Accumulator
//   - acc is shared by RMAX and RMIN. Switching between them without CLR continues from the current acc.
//   - Each accepted mode 5/6 sample clears acc_empty and increments acc_count.
//   - acc_count saturates at 2^COUNT_W-1 and never wraps.
//   - Modes 0-4 never touch acc, acc_count or sticky_of.
//   Reset
//   - out_valid=0, out_data=0, acc=0, acc_empty=1, acc_count=0, sticky_of=0.
//   - in_ready=1 in the cycle after reset.
//   - Reset mid-transfer discards any pending result. No output is produced for it.
//   - Reset wins over a simultaneous accept.
// TESTING (WIDTH=4, COUNT_W=8 unless noted)
//   - Static modes:
//     - x=9, y=3, unsigned: GT -> 5'b0_0001, LT -> 5'b0_0000, MAX -> 5'b0_1001, MIN -> 5'b0_0011.
//     - Same operands with is_signed=1: GT -> 0, MAX -> 3.
//     - EQ on x=y=7 -> 1.
//   - Running max:
//     - CLR, then RMAX with x=2,5,1,-- (3 samples) -> results 2,5,5.
//     - acc_count=3, acc_empty=0.
//     - Then RMIN with x=4 -> 4.
//   - Sticky OF:
//     - RMAX samples with of_in=0,1,0 -> of bit 0,1,1.
//     - CLR -> of bit 0.
//     - MAX with of_in=0 after that -> of bit 0.
//   - Backpressure:
//     - Hold out_ready=0 for 5 cycles with in_valid=1.
//     - Required: in_ready=0, out_data stable, acc_count unchanged.
//     - Release out_ready: one result per cycle, no samples lost or duplicated.
//   - Saturation: COUNT_W=2, 6 RMAX accepts -> acc_count=3.
//   - Reset: assert reset while out_valid=1 && out_ready=0.
//     - Next cycle: out_valid=0, acc_empty=1, acc_count=0, in_ready=1.

Source files
------------

// File: rtl/compare_stream_unit_if.sv
// Operand/result stream bundle for compare_stream_unit.
// master drives operands and out_ready; slave is the compare unit.
interface compare_stream_unit_if #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [2:0]         mode;
  logic               is_signed;
  logic               of_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     out_data;
  logic [COUNT_W-1:0] acc_count;
  logic               acc_empty;

  modport master (
    output in_valid, x, y, mode, is_signed, of_in, out_ready,
    input  in_ready, out_valid, out_data, acc_count, acc_empty
  );

  modport slave (
    input  in_valid, x, y, mode, is_signed, of_in, out_ready,
    output in_ready, out_valid, out_data, acc_count, acc_empty
  );
endinterface

// File: rtl/compare_stream_unit.sv
// Streaming compare unit: EQ/GT/LT/MAX/MIN plus running MAX/MIN accumulator with sticky overflow.
// Latency: one cycle from accept to out_valid.
// Backpressure: single output register; in_ready = !out_valid || out_ready, state frozen while stalled.
module compare_stream_unit #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  compare_stream_unit_if.slave cs
);
  localparam logic [2:0] M_EQ   = 3'd0;
  localparam logic [2:0] M_GT   = 3'd1;
  localparam logic [2:0] M_LT   = 3'd2;
  localparam logic [2:0] M_MAX  = 3'd3;
  localparam logic [2:0] M_MIN  = 3'd4;
  localparam logic [2:0] M_RMAX = 3'd5;
  localparam logic [2:0] M_RMIN = 3'd6;
  localparam logic [2:0] M_CLR  = 3'd7;

  typedef struct packed {
    logic             of;
    logic [WIDTH-1:0] res;
  } result_t;

  logic               out_valid_q;
  result_t            out_q;
  logic [WIDTH-1:0]   acc;
  logic               acc_empty_q;
  logic [COUNT_W-1:0] acc_count_q;
  logic               sticky_of;

  logic               accept;
  logic               drain;
  logic               x_lt_y, x_gt_y, x_eq_y, x_lt_acc, x_gt_acc;
  result_t            result_nxt;
  logic [WIDTH-1:0]   acc_nxt;

  function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic sgn);
    return sgn ? ($signed(a) < $signed(b)) : (a < b);
  endfunction

  assign cs.in_ready  = !out_valid_q || cs.out_ready;
  assign accept       = cs.in_valid && cs.in_ready;
  assign drain        = out_valid_q && cs.out_ready;

  assign cs.out_valid = out_valid_q;
  assign cs.out_data  = out_q;
  assign cs.acc_count = acc_count_q;
  assign cs.acc_empty = acc_empty_q;

  assign x_lt_y   = less(cs.x, cs.y, cs.is_signed);
  assign x_gt_y   = less(cs.y, cs.x, cs.is_signed);
  assign x_eq_y   = (cs.x == cs.y);
  assign x_lt_acc = less(cs.x, acc, cs.is_signed);
  assign x_gt_acc = less(acc, cs.x, cs.is_signed);

  always_comb begin
    result_nxt.of  = cs.of_in;
    result_nxt.res = '0;
    acc_nxt        = acc;
    unique case (cs.mode)
      M_EQ:   result_nxt.res = {{(WIDTH-1){1'b0}}, x_eq_y};
      M_GT:   result_nxt.res = {{(WIDTH-1){1'b0}}, x_gt_y};
      M_LT:   result_nxt.res = {{(WIDTH-1){1'b0}}, x_lt_y};
      M_MAX:  result_nxt.res = x_gt_y ? cs.x : cs.y;
      M_MIN:  result_nxt.res = x_lt_y ? cs.x : cs.y;
      M_RMAX: begin
        acc_nxt        = (acc_empty_q || x_gt_acc) ? cs.x : acc;
        result_nxt.res = acc_nxt;
        result_nxt.of  = sticky_of | cs.of_in;
      end
      M_RMIN: begin
        acc_nxt        = (acc_empty_q || x_lt_acc) ? cs.x : acc;
        result_nxt.res = acc_nxt;
        result_nxt.of  = sticky_of | cs.of_in;
      end
      M_CLR:  result_nxt.of = 1'b0;
      default: result_nxt.of = cs.of_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      acc         <= '0;
      acc_empty_q <= 1'b1;
      acc_count_q <= '0;
      sticky_of   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= result_nxt;
      if (cs.mode == M_RMAX || cs.mode == M_RMIN) begin
        acc         <= acc_nxt;
        acc_empty_q <= 1'b0;
        sticky_of   <= result_nxt.of;
        // saturate rather than wrap so a long run never looks like a fresh one
        if (acc_count_q != '1)
          acc_count_q <= acc_count_q + COUNT_W'(1);
      end else if (cs.mode == M_CLR) begin
        acc         <= '0;
        acc_empty_q <= 1'b1;
        acc_count_q <= '0;
        sticky_of   <= 1'b0;
      end
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_compare_stream_unit.sv
// Scoreboarded bench for compare_stream_unit: directed vectors with hand-computed results.
module tb_compare_stream_unit;
  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  logic [4:0] exp_q[$];
  string      name_q[$];

  compare_stream_unit_if #(.WIDTH(4), .COUNT_W(8)) bus ();
  compare_stream_unit_if #(.WIDTH(4), .COUNT_W(2)) bus2 ();

  compare_stream_unit #(.WIDTH(4), .COUNT_W(8)) dut (.clk(clk), .reset(reset), .cs(bus));
  compare_stream_unit #(.WIDTH(4), .COUNT_W(2)) dut_sat (.clk(clk), .reset(reset), .cs(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [3:0] xv, input logic [3:0] yv,
                      input logic sg, input logic ofv, input logic [4:0] exp, input string name);
    int w;
    tick();
    bus.mode = m; bus.x = xv; bus.y = yv; bus.is_signed = sg; bus.of_in = ofv;
    bus.in_valid = 1'b1;
    #1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      #2;
      w++;
    end
    if (!bus.in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL %s: in_ready timeout, got 0, expected 1", name);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      name_q.push_back(name);
      n_push++;
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    tick();
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor: samples between the driver's negedge update and the next rising edge
  initial begin
    logic [4:0] e;
    string      nm;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got %0h, expected no result", bus.out_data);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, bus.out_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 0; bus.x = 0; bus.y = 0; bus.mode = 0; bus.is_signed = 0;
    bus.of_in = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.x = 0; bus2.y = 0; bus2.mode = 0; bus2.is_signed = 0;
    bus2.of_in = 0; bus2.out_ready = 0;
    repeat (3) @(posedge clk);
    tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_acc_empty", bus.acc_empty, 1);
    check("rst_acc_count", bus.acc_count, 0);
    check("rst_out_data", bus.out_data, 0);

    bus.out_ready = 1'b1;
    send(3'd1, 4'd9, 4'd3, 1'b0, 1'b0, 5'h01, "gt_u");
    send(3'd2, 4'd9, 4'd3, 1'b0, 1'b0, 5'h00, "lt_u");
    send(3'd3, 4'd9, 4'd3, 1'b0, 1'b0, 5'h09, "max_u");
    send(3'd4, 4'd9, 4'd3, 1'b0, 1'b0, 5'h03, "min_u");
    send(3'd1, 4'd9, 4'd3, 1'b1, 1'b0, 5'h00, "gt_s");
    send(3'd3, 4'd9, 4'd3, 1'b1, 1'b0, 5'h03, "max_s");
    send(3'd2, 4'd9, 4'd3, 1'b1, 1'b1, 5'h11, "lt_s_of");
    send(3'd4, 4'd9, 4'd3, 1'b1, 1'b0, 5'h09, "min_s");
    send(3'd0, 4'd7, 4'd7, 1'b0, 1'b0, 5'h01, "eq_hit");
    send(3'd0, 4'd7, 4'd6, 1'b0, 1'b0, 5'h00, "eq_miss");
    idle(2);
    check("static_acc_count", bus.acc_count, 0);
    check("static_acc_empty", bus.acc_empty, 1);

    send(3'd7, 4'd0, 4'd0, 1'b0, 1'b0, 5'h00, "clr0");
    send(3'd5, 4'd2, 4'd0, 1'b0, 1'b0, 5'h02, "rmax_2");
    send(3'd5, 4'd5, 4'd0, 1'b0, 1'b0, 5'h05, "rmax_5");
    send(3'd5, 4'd1, 4'd0, 1'b0, 1'b0, 5'h05, "rmax_1");
    idle(2);
    check("run_acc_count", bus.acc_count, 3);
    check("run_acc_empty", bus.acc_empty, 0);
    send(3'd6, 4'd4, 4'd0, 1'b0, 1'b0, 5'h04, "rmin_4");

    send(3'd7, 4'd0, 4'd0, 1'b0, 1'b0, 5'h00, "clr1");
    send(3'd5, 4'd1, 4'd0, 1'b0, 1'b0, 5'h01, "sticky_0");
    send(3'd5, 4'd3, 4'd0, 1'b0, 1'b1, 5'h13, "sticky_1");
    send(3'd5, 4'd2, 4'd0, 1'b0, 1'b0, 5'h13, "sticky_hold");
    send(3'd7, 4'd0, 4'd0, 1'b0, 1'b1, 5'h00, "sticky_clr");
    send(3'd3, 4'd1, 4'd2, 1'b0, 1'b0, 5'h02, "max_after_clr");
    send(3'd5, 4'he, 4'd0, 1'b1, 1'b0, 5'h0e, "rmax_s_neg2");
    send(3'd5, 4'd1, 4'd0, 1'b1, 1'b0, 5'h01, "rmax_s_1");
    send(3'd6, 4'hf, 4'd0, 1'b1, 1'b0, 5'h0f, "rmin_s_neg1");

    // Backpressure: one result parked, a second offered for five stalled cycles
    send(3'd7, 4'd0, 4'd0, 1'b0, 1'b0, 5'h00, "clr2");
    idle(2);
    tick();
    bus.out_ready = 1'b0;
    send(3'd5, 4'd3, 4'd0, 1'b0, 1'b0, 5'h03, "bp_first");
    tick();
    bus.mode = 3'd5; bus.x = 4'd7; bus.in_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, 5'h03);
      check("bp_acc_count", bus.acc_count, 1);
    end
    tick();
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    exp_q.push_back(5'h07); name_q.push_back("bp_second"); n_push++;
    @(posedge clk);
    send(3'd5, 4'd4, 4'd0, 1'b0, 1'b0, 5'h07, "bp_third");
    send(3'd6, 4'd1, 4'd0, 1'b0, 1'b0, 5'h01, "bp_fourth");
    idle(2);
    check("bp_final_count", bus.acc_count, 4);

    // Saturating counter on the narrow instance
    bus2.out_ready = 1'b1; bus2.mode = 3'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus2.x = 4'(i + 1);
      bus2.in_valid = 1'b1;
    end
    tick();
    bus2.in_valid = 1'b0;
    #1;
    check("sat_acc_count", bus2.acc_count, 3);
    check("sat_acc_empty", bus2.acc_empty, 0);
    check("sat_out_data", bus2.out_data, 5'h06);

    // Reset while a result is parked, with a new sample offered at the same edge
    tick();
    bus.out_ready = 1'b0;
    send(3'd5, 4'd5, 4'd0, 1'b0, 1'b0, 5'h05, "pre_reset");
    tick();
    bus.out_ready = 1'b1; bus.mode = 3'd5; bus.x = 4'd9; bus.in_valid = 1'b1;
    reset = 1'b1;
    exp_q.delete(); name_q.delete(); n_push--;
    @(posedge clk);
    tick();
    reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_acc_empty", bus.acc_empty, 1);
    check("mrst_acc_count", bus.acc_count, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    check("mrst_out_data", bus.out_data, 0);
    check("mrst_sat_count", bus2.acc_count, 0);
    tick();
    bus.out_ready = 1'b1;
    send(3'd0, 4'd3, 4'd3, 1'b0, 1'b0, 5'h01, "post_rst_eq");
    send(3'd5, 4'd2, 4'd0, 1'b0, 1'b0, 5'h02, "post_rst_rmax");
    idle(3);
    check("sb_empty", exp_q.size(), 0);
    check("result_count", n_pop, n_push);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
